// File: rtl/mcpu_ctrl_fsm.sv
// rtl/mcpu_ctrl_fsm.sv - multi-cycle MIPS control FSM (optional MCPU_CTRL_MEM_WAIT_EN memory handshake)
module mcpu_ctrl_fsm #(
    parameter int ICNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_ce,
    output logic              ir_ce,
    output logic              mdr_ce,
    output logic              ab_ce,
    output logic              aluout_ce,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              iord,
    output logic              reg_wr,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_ctrl,
    output logic [1:0]        pc_src,
    output logic              illegal,
    output logic [3:0]        state,
    output logic [ICNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_BEQ   = 4'd8,
        S_JMP   = 4'd9,
        S_IEX   = 4'd10,
        S_IWB   = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur, nxt;
    logic   ill_q, ill_nxt;
    logic   retire;
    logic   mem_done;
    logic   funct_ok;
    logic [2:0] rex_ctrl;

`ifdef MCPU_CTRL_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done = 1'b1;
`endif

    always_comb begin
        funct_ok = 1'b1;
        rex_ctrl = ALU_ADD;
        case (funct)
            6'h20:   rex_ctrl = ALU_ADD;
            6'h22:   rex_ctrl = ALU_SUB;
            6'h24:   rex_ctrl = ALU_AND;
            6'h25:   rex_ctrl = ALU_OR;
            6'h2A:   rex_ctrl = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        {pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce} = '0;
        {mem_rd, mem_wr, iord}                   = '0;
        {reg_wr, reg_dst, mem_to_reg}            = '0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_ctrl  = ALU_ADD;
        pc_src    = 2'b00;
        nxt       = S_IF;
        ill_nxt   = 1'b0;
        retire    = 1'b0;
        case (cur)
            S_IF: begin
                mem_rd    = 1'b1;
                ir_ce     = mem_done;
                pc_ce     = mem_done;
                alu_src_b = 2'b01;
                nxt       = mem_done ? S_ID : S_IF;
            end
            S_ID: begin
                ab_ce     = 1'b1;
                aluout_ce = 1'b1;
                alu_src_b = 2'b11;
                case (opcode)
                    6'h23, 6'h2B:        nxt = S_MADDR;
                    6'h00:               nxt = S_REX;
                    6'h04:               nxt = S_BEQ;
                    6'h02:               nxt = S_JMP;
                    6'h08, 6'h0C, 6'h0D: nxt = S_IEX;
                    default:             ill_nxt = 1'b1;
                endcase
            end
            S_MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                aluout_ce = 1'b1;
                nxt       = (opcode == 6'h2B) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                mdr_ce = mem_done;
                nxt    = mem_done ? S_MWB : S_MRD;
            end
            S_MWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                nxt    = mem_done ? S_IF : S_MWR;
                retire = mem_done;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                aluout_ce = 1'b1;
                alu_ctrl  = rex_ctrl;
                nxt       = funct_ok ? S_RWB : S_IF;
                ill_nxt   = ~funct_ok;
            end
            S_RWB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_ce     = zero;
                retire    = 1'b1;
            end
            S_JMP: begin
                pc_src = 2'b10;
                pc_ce  = 1'b1;
                retire = 1'b1;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                aluout_ce = 1'b1;
                alu_ctrl  = (opcode == 6'h0C) ? ALU_AND :
                            (opcode == 6'h0D) ? ALU_OR  : ALU_ADD;
                nxt       = S_IWB;
            end
            S_IWB: begin
                reg_wr = 1'b1;
                retire = 1'b1;
            end
            default: nxt = S_IF;
        endcase
        // Reset must silence every strobe at once, not just from the next edge.
        if (rst) begin
            {pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce} = '0;
            {mem_rd, mem_wr, iord}                   = '0;
            {reg_wr, reg_dst, mem_to_reg}            = '0;
            alu_src_a = 1'b0;
            alu_src_b = 2'b00;
            alu_ctrl  = 3'b000;
            pc_src    = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= S_IF;
            ill_q     <= 1'b0;
            instr_cnt <= '0;
        end else begin
            cur   <= nxt;
            ill_q <= ill_nxt;
            if (retire)
                instr_cnt <= instr_cnt + {{(ICNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign state   = cur;
    assign illegal = ill_q;

endmodule
